mj32_control_fsm: RTL and testbench



---
 rtl/mj32_control_fsm_if.sv | 43 ++++
 rtl/mj32_control_fsm.sv | 143 ++++++++++++++
 tb/tb_mj32_control_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mj32_control_fsm_if.sv
// rtl/mj32_control_fsm_if.sv - MJ32 control sequencer handshake/strobe bundle
interface mj32_control_fsm_if #(
    parameter int RET_W = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic             ir_load;
    logic             register_type;
    logic             immediate_type;
    logic             load_type;
    logic             store_type;
    logic             branch_type;
    logic             call_type;
    logic             load_immediate_type;
    logic             jump_type;
    logic             branch_taken;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             reg_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             trap;
    logic [2:0]       state;
    logic [RET_W-1:0] retired_count;

    modport master (
        output imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we, pc_we,
               pc_sel, trap, state, retired_count,
        input  imem_ack, dmem_ack, branch_taken,
               register_type, immediate_type, load_type, store_type,
               branch_type, call_type, load_immediate_type, jump_type
    );

    modport slave (
        input  imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we, pc_we,
               pc_sel, trap, state, retired_count,
        output imem_ack, dmem_ack, branch_taken,
               register_type, immediate_type, load_type, store_type,
               branch_type, call_type, load_immediate_type, jump_type
    );
endinterface

// File: rtl/mj32_control_fsm.sv
// rtl/mj32_control_fsm.sv - MJ32 multi-cycle control sequencer
module mj32_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RET_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    mj32_control_fsm_if.master     bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_e;

    localparam int C_REG  = 7;
    localparam int C_IMM  = 6;
    localparam int C_LD   = 5;
    localparam int C_ST   = 4;
    localparam int C_BR   = 3;
    localparam int C_CALL = 2;
    localparam int C_LI   = 1;
    localparam int C_JMP  = 0;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cls_q, cls_d;
    logic             taken_q, taken_d;
    logic [RET_W-1:0] ret_q, ret_d;

    logic [7:0] flags;
    logic       flags_one;
    logic [7:0] cnt_inc;

    logic       imem_req, ir_load, alu_en, dmem_req, dmem_we;
    logic       reg_we, pc_we, trap;
    logic [1:0] pc_sel;

    assign flags = {bus.register_type, bus.immediate_type, bus.load_type,
                    bus.store_type, bus.branch_type, bus.call_type,
                    bus.load_immediate_type, bus.jump_type};
    assign flags_one = (flags != 8'd0) && ((flags & (flags - 8'd1)) == 8'd0);
    // Saturating wait count; reaching TMO without ack means the memory hung.
    assign cnt_inc = (cnt_q >= TMO) ? TMO : cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cls_q   <= 8'd0;
            taken_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            taken_q <= taken_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = 8'd0;
        cls_d    = cls_q;
        taken_d  = taken_q;
        ret_d    = ret_q;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        trap     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d   = flags;
                state_d = flags_one ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                alu_en  = 1'b1;
                taken_d = bus.branch_taken;
                state_d = (cls_q[C_LD] || cls_q[C_ST]) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = cls_q[C_ST];
                if (bus.dmem_ack) begin
                    state_d = S_WRITEBACK;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                pc_we  = 1'b1;
                reg_we = cls_q[C_REG] | cls_q[C_IMM] | cls_q[C_LD] |
                         cls_q[C_LI]  | cls_q[C_CALL] | cls_q[C_JMP];
                if (cls_q[C_JMP])                pc_sel = 2'b10;
                else if (cls_q[C_CALL])          pc_sel = 2'b11;
                else if (cls_q[C_BR] && taken_q) pc_sel = 2'b01;
                ret_d   = ret_q + 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase
    end

    assign bus.imem_req      = imem_req;
    assign bus.ir_load       = ir_load;
    assign bus.alu_en        = alu_en;
    assign bus.dmem_req      = dmem_req;
    assign bus.dmem_we       = dmem_we;
    assign bus.reg_we        = reg_we;
    assign bus.pc_we         = pc_we;
    assign bus.pc_sel        = pc_sel;
    assign bus.trap          = trap;
    assign bus.state         = state_q;
    assign bus.retired_count = ret_q;
endmodule

// File: tb/tb_mj32_control_fsm.sv
// tb/tb_mj32_control_fsm.sv - directed vector bench for mj32_control_fsm
module tb_mj32_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_ret = 0;

    mj32_control_fsm_if #(.RET_W(32)) bus ();

    mj32_control_fsm #(.MEM_TIMEOUT(15), .RET_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] flags;
        bit         bt_ex;
        bit         bt_wb;
        int         imem_dly;
        int         dmem_dly;
        bit         exp_we;
        bit         exp_dwe;
        logic [1:0] exp_sel;
        int         exp_cyc;
        int         exp_mem;
    } vec_t;

    localparam logic [7:0] F_ADD = 8'b1000_0000;
    localparam logic [7:0] F_IMM = 8'b0100_0000;
    localparam logic [7:0] F_LD  = 8'b0010_0000;
    localparam logic [7:0] F_ST  = 8'b0001_0000;
    localparam logic [7:0] F_BR  = 8'b0000_1000;
    localparam logic [7:0] F_JR  = 8'b0000_0100;
    localparam logic [7:0] F_LI  = 8'b0000_0010;
    localparam logic [7:0] F_JMP = 8'b0000_0001;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [7:0] f);
        {bus.register_type, bus.immediate_type, bus.load_type, bus.store_type,
         bus.branch_type, bus.call_type, bus.load_immediate_type, bus.jump_type} = f;
    endtask

    task automatic do_reset();
        set_flags(8'd0);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.branch_taken = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset outputs", {bus.imem_req, bus.ir_load, bus.alu_en, bus.dmem_req, bus.dmem_we,
                              bus.reg_we, bus.pc_we, bus.pc_sel, bus.trap, bus.state}, 64'd0);
        chk("reset retired", bus.retired_count, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        #1;
        chk("idle after reset", {bus.imem_req, bus.state}, 64'd0);
        @(negedge clk);
        chk("idle to fetch", bus.state, 64'd1);
    endtask

    // Precondition: sampled at a falling edge with the FSM in FETCH.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        int fw = 0;
        int mw = 0;
        int mem = 0;
        bit done = 0;
        bit fetch_bad = 0;
        bit mem_bad = 0;
        bit ex_bad = 0;
        logic we = 1'b0;
        logic pcwe = 1'b0;
        logic [1:0] sel = 2'b00;
        set_flags(v.flags);
        while (!done && cyc < 200) begin
            case (bus.state)
                3'd1: begin
                    bus.imem_ack = (fw >= v.imem_dly);
                    fw++;
                    #1;
                    if (bus.imem_req !== 1'b1 || bus.ir_load !== bus.imem_ack) fetch_bad = 1;
                end
                3'd2: ;
                3'd3: begin
                    bus.branch_taken = v.bt_ex;
                    #1;
                    if (bus.alu_en !== 1'b1 || bus.pc_we !== 1'b0) ex_bad = 1;
                end
                3'd4: begin
                    bus.dmem_ack = (mw >= v.dmem_dly);
                    mw++;
                    mem++;
                    #1;
                    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== v.exp_dwe) mem_bad = 1;
                end
                3'd5: begin
                    bus.branch_taken = v.bt_wb;
                    #1;
                    we   = bus.reg_we;
                    sel  = bus.pc_sel;
                    pcwe = bus.pc_we;
                    done = 1;
                end
                default: cyc = 1000;
            endcase
            cyc++;
            @(negedge clk);
        end
        exp_ret++;
        chk($sformatf("v%0d reached writeback", idx), done, 64'd1);
        chk($sformatf("v%0d cycles", idx), cyc, v.exp_cyc);
        chk($sformatf("v%0d memory cycles", idx), mem, v.exp_mem);
        chk($sformatf("v%0d fetch handshake", idx), fetch_bad, 64'd0);
        chk($sformatf("v%0d execute strobe", idx), ex_bad, 64'd0);
        chk($sformatf("v%0d dmem req/we", idx), mem_bad, 64'd0);
        chk($sformatf("v%0d reg_we", idx), we, v.exp_we);
        chk($sformatf("v%0d pc_sel", idx), sel, v.exp_sel);
        chk($sformatf("v%0d pc_we", idx), pcwe, 64'd1);
        chk($sformatf("v%0d back to fetch", idx), bus.state, 64'd1);
        chk($sformatf("v%0d retired", idx), bus.retired_count, exp_ret);
    endtask

    task automatic fault_decode(input logic [7:0] f, input string name);
        set_flags(f);
        bus.imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({name, " state"}, bus.state, 64'd7);
        chk({name, " trap"}, bus.trap, 64'd1);
        set_flags(F_ADD);
        repeat (5) @(negedge clk);
        chk({name, " sticky"}, {bus.trap, bus.state}, {1'b1, 3'd7});
        chk({name, " strobes idle"}, {bus.imem_req, bus.ir_load, bus.alu_en, bus.dmem_req,
                                      bus.reg_we, bus.pc_we}, 64'd0);
        chk({name, " retired frozen"}, bus.retired_count, exp_ret);
    endtask

    task automatic timeout_run(input bit in_mem, input string name);
        int n = 0;
        logic [2:0] tgt;
        tgt = in_mem ? 3'd4 : 3'd1;
        set_flags(in_mem ? F_LD : F_ADD);
        bus.imem_ack = in_mem;
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 100 && bus.state !== 3'd7; i++) begin
            if (bus.state == tgt) n++;
            @(negedge clk);
        end
        chk({name, " wait cycles"}, n, 64'd15);
        chk({name, " trap"}, {bus.trap, bus.state}, {1'b1, 3'd7});
        chk({name, " requests dropped"}, {bus.imem_req, bus.dmem_req}, 64'd0);
        chk({name, " retired frozen"}, bus.retired_count, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{F_ADD, 0, 0, 0,  0, 1, 0, 2'b00, 4,  0};
        vecs[1]  = '{F_IMM, 0, 0, 0,  0, 1, 0, 2'b00, 4,  0};
        vecs[2]  = '{F_LD,  0, 0, 0,  3, 1, 0, 2'b00, 8,  4};
        vecs[3]  = '{F_ST,  0, 0, 0,  3, 0, 1, 2'b00, 8,  4};
        vecs[4]  = '{F_BR,  1, 0, 0,  0, 0, 0, 2'b01, 4,  0};
        vecs[5]  = '{F_BR,  0, 1, 0,  0, 0, 0, 2'b00, 4,  0};
        vecs[6]  = '{F_JMP, 0, 0, 0,  0, 1, 0, 2'b10, 4,  0};
        vecs[7]  = '{F_JR,  0, 0, 0,  0, 1, 0, 2'b11, 4,  0};
        vecs[8]  = '{F_LI,  0, 0, 0,  0, 1, 0, 2'b00, 4,  0};
        vecs[9]  = '{F_ADD, 0, 0, 2,  0, 1, 0, 2'b00, 6,  0};
        vecs[10] = '{F_LD,  0, 0, 0, 14, 1, 0, 2'b00, 19, 15};
        vecs[11] = '{F_ST,  0, 0, 0,  0, 0, 1, 2'b00, 5,  1};

        set_flags(8'd0);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.branch_taken = 1'b0;
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) run_vec(vecs[0], 100 + i);
        chk("add stream retired", bus.retired_count, 64'd10);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        fault_decode(8'd0, "no class flag");

        do_reset();
        run_vec(vecs[0], 200);
        fault_decode(F_ADD | F_LD, "two class flags");

        do_reset();
        timeout_run(1'b1, "dmem timeout");

        do_reset();
        timeout_run(1'b0, "imem timeout");

        do_reset();
        run_vec(vecs[0], 300);
        set_flags(F_LD);
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b0;
        for (int i = 0; i < 20 && bus.state !== 3'd4; i++) @(negedge clk);
        chk("memory before reset", {bus.state, bus.dmem_req}, {3'd4, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        chk("async reset drop", {bus.dmem_req, bus.dmem_we, bus.state}, 64'd0);
        chk("async reset retired", bus.retired_count, 64'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
